// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, sequences the boot hold,
// arbitrates branch/jump redirects, handles memory wait states and latches a
// sticky error when the instruction memory stops responding.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BOOT_HOLD   = 2,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero_alu,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic        if_valid,
  output logic        flush,
  output logic        imem_err
);

  typedef enum logic [1:0] {
    StBoot,
    StFetch,
    StWait,
    StErr
  } state_e;

  // Last boot count value before fetching starts; boot counter runs 0..BootLast.
  localparam logic [3:0] BootLast   = 4'(BOOT_HOLD - 1);
  localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  logic        take;
  logic        jmp;
  logic        redirect;
  logic [31:0] jump_target;
  logic [31:0] redirect_target;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;

  // Branch in EX is older than the jump in ID, so it wins.
  assign take     = branch & zero_alu;
  assign jmp      = jump & ~take;
  assign redirect = take | jmp;

  assign jump_target     = {pc_plus4[31:28], jump_index, 2'b00};
  // Branch target is used as-is, including its low two bits.
  assign redirect_target = take ? branch_target : jump_target;

  assign imem_err = (state_q == StErr);

  // Next-state, next-PC and per-cycle handshake outputs.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    boot_cnt_d = boot_cnt_q;
    wait_cnt_d = wait_cnt_q;
    imem_req   = 1'b0;
    if_valid   = 1'b0;
    flush      = 1'b0;

    unique case (state_q)
      StBoot: begin
        if (boot_cnt_q >= BootLast) begin
          state_d = StFetch;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end

      StFetch, StWait: begin
        if (redirect) begin
          // Redirect overrides stall and any outstanding request.
          flush      = 1'b1;
          pc_d       = redirect_target;
          wait_cnt_d = 8'd0;
          state_d    = StFetch;
        end else begin
          imem_req = 1'b1;
          if (imem_ready) begin
            wait_cnt_d = 8'd0;
            state_d    = StFetch;
            // A stalled return is dropped; the same address is fetched again.
            if (!stall) begin
              if_valid = 1'b1;
              pc_d     = pc_plus4;
            end
          end else if (wait_cnt_q >= TimeoutCnt) begin
            state_d = StErr;
          end else begin
            state_d = StWait;
            if (wait_cnt_q != 8'hFF) begin
              wait_cnt_d = wait_cnt_q + 8'd1;
            end
          end
        end
      end

      StErr: begin
        // Frozen until reset.
      end

      default: begin
        state_d = StBoot;
      end
    endcase
  end

  // State, PC and counter registers; reset takes effect without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      boot_cnt_q <= 4'd0;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      boot_cnt_q <= boot_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus pushes the expected accepted
// fetch or flush into a queue, a negedge monitor pops and compares whenever
// the DUT asserts if_valid or flush. Direct checks cover PC, request and
// error behaviour at specific points.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch;
  logic        zero_alu;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic        if_valid;
  logic        flush;
  logic        imem_err;

  typedef struct packed {
    logic        is_flush;
    logic [31:0] addr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_pc;

  fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .BOOT_HOLD  (2),
    .MEM_TIMEOUT(15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch       (branch),
    .zero_alu     (zero_alu),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_index   (jump_index),
    .imem_ready   (imem_ready),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .imem_req     (imem_req),
    .if_valid     (if_valid),
    .flush        (flush),
    .imem_err     (imem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic is_flush, input logic [31:0] addr);
    exp_t e;
    e.is_flush = is_flush;
    e.addr     = addr;
    exp_q.push_back(e);
  endtask

  task automatic clear_redirect();
    branch   = 1'b0;
    zero_alu = 1'b0;
    jump     = 1'b0;
  endtask

  // Sequential fetches with memory ready and no stall.
  task automatic run_seq(input int n);
    for (int i = 0; i < n; i++) begin
      push(1'b0, m_pc);
      step();
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Monitor: compare every accepted fetch / flush against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (flush && if_valid) begin
        n_tests++;
        n_fail++;
        $display("FAIL flush_and_valid: both high at pc %h, expected exclusive", pc);
      end else if (flush || if_valid) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out: flush=%0b if_valid=%0b pc=%h, expected none",
                   flush, if_valid, pc);
        end else begin
          e = exp_q.pop_front();
          if (e.is_flush !== flush || e.addr !== pc) begin
            n_fail++;
            $display("FAIL scoreboard: got flush=%0b pc=%h, expected flush=%0b pc=%h",
                     flush, pc, e.is_flush, e.addr);
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    stall         = 1'b0;
    branch        = 1'b0;
    zero_alu      = 1'b0;
    branch_target = 32'h0;
    jump          = 1'b0;
    jump_index    = 26'h0;
    imem_ready    = 1'b1;
    m_pc          = 32'h0;

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    check("rst_pc", pc, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_valid", {31'b0, if_valid}, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_err", {31'b0, imem_err}, 32'h0);

    // Boot hold: request rises two edges after release.
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    #1 check("boot_req_low", {31'b0, imem_req}, 32'h0);
    step();
    #1 check("boot_req_high", {31'b0, imem_req}, 32'h1);

    // Sequential fetch 0x0 .. 0x1C.
    run_seq(8);
    check("seq_pc", pc, 32'h20);

    // Stall for 3 cycles at 0x20.
    stall = 1'b1;
    #1 check("stall_valid", {31'b0, if_valid}, 32'h0);
    check("stall_req", {31'b0, imem_req}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc_hold", pc, 32'h20);
    end
    stall = 1'b0;

    // Memory not ready for 4 cycles.
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("wait_pc_hold", pc, 32'h20);
    end
    #1 check("wait_req", {31'b0, imem_req}, 32'h1);
    imem_ready = 1'b1;
    push(1'b0, 32'h20);
    step();
    check("wait_done_pc", pc, 32'h24);
    m_pc = 32'h24;
    run_seq(7);
    check("seq2_pc", pc, 32'h40);

    // Branch beats jump.
    branch        = 1'b1;
    zero_alu      = 1'b1;
    branch_target = 32'h100;
    jump          = 1'b1;
    jump_index    = 26'h10;
    push(1'b1, 32'h40);
    #1 check("br_flush", {31'b0, flush}, 32'h1);
    check("br_valid", {31'b0, if_valid}, 32'h0);
    check("br_req", {31'b0, imem_req}, 32'h0);
    step();
    check("br_pc", pc, 32'h100);

    // Branch not taken: jump to {0x0, 0x10, 00} = 0x40.
    zero_alu = 1'b0;
    push(1'b1, 32'h100);
    step();
    clear_redirect();
    check("jmp_pc", pc, 32'h40);

    // Wrap at top of address space.
    branch        = 1'b1;
    zero_alu      = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    push(1'b1, 32'h40);
    step();
    clear_redirect();
    #1 check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    m_pc = 32'hFFFF_FFFC;
    run_seq(2);
    check("wrap_seq_pc", pc, 32'h4);

    // Unaligned branch target is loaded unchanged.
    branch        = 1'b1;
    zero_alu      = 1'b1;
    branch_target = 32'h203;
    push(1'b1, 32'h4);
    step();
    clear_redirect();
    #1 check("unaligned_pc", pc, 32'h203);
    check("unaligned_pc_plus4", pc_plus4, 32'h207);

    // Jump to {0x0, 0xC0, 00} = 0x300.
    jump       = 1'b1;
    jump_index = 26'hC0;
    push(1'b1, 32'h203);
    step();
    clear_redirect();
    check("jmp2_pc", pc, 32'h300);

    // Redirect while waiting clears the wait counter.
    imem_ready = 1'b0;
    repeat (3) step();
    check("wait2_pc", pc, 32'h300);
    branch        = 1'b1;
    zero_alu      = 1'b1;
    branch_target = 32'h400;
    push(1'b1, 32'h300);
    #1 check("wait_redir_flush", {31'b0, flush}, 32'h1);
    step();
    clear_redirect();
    check("wait_redir_pc", pc, 32'h400);

    // Timeout: 16 not-ready cycles from a cleared counter.
    repeat (15) step();
    #1 check("pre_timeout_err", {31'b0, imem_err}, 32'h0);
    check("pre_timeout_req", {31'b0, imem_req}, 32'h1);
    step();
    #1 check("timeout_err", {31'b0, imem_err}, 32'h1);
    check("timeout_req", {31'b0, imem_req}, 32'h0);

    // Redirects ignored in error state.
    branch        = 1'b1;
    zero_alu      = 1'b1;
    branch_target = 32'h500;
    imem_ready    = 1'b1;
    #1 check("err_flush", {31'b0, flush}, 32'h0);
    check("err_valid", {31'b0, if_valid}, 32'h0);
    step();
    check("err_pc_frozen", pc, 32'h400);
    check("err_sticky", {31'b0, imem_err}, 32'h1);

    // Asynchronous reset clears the error before any clock edge.
    reset = 1'b1;
    #1 check("async_rst_err", {31'b0, imem_err}, 32'h0);
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_pc_plus4", pc_plus4, 32'h4);
    check("async_rst_req", {31'b0, imem_req}, 32'h0);
    check("async_rst_flush", {31'b0, flush}, 32'h0);
    clear_redirect();
    repeat (2) step();
    check("scoreboard_empty", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter BOOT_HOLD, 2, cycles after reset release before the first fetch request (range 1..15).
REQ-003 Parameter MEM_TIMEOUT, 15, maximum consecutive wait cycles on an outstanding fetch before error (range 1..255).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 stall  input  1  hazard-unit hold: keep PC and block fetch advance.
REQ-007 branch  input  1  branch decoded in EX.
REQ-008 zero_alu  input  1  ALU zero flag from EX.
REQ-009 branch_target  input  32  branch target address from the EX adder.
REQ-010 jump  input  1  jump decoded in ID.
REQ-011 jump_index  input  26  instruction[25:0] of the jump in ID.
REQ-012 imem_ready  input  1  instruction memory returns valid data for the current pc this cycle.
REQ-013 pc  output  32  registered fetch address.
REQ-014 pc_plus4  output  32  pc + 4, combinational.
REQ-015 imem_req  output  1  fetch request for address pc.
REQ-016 if_valid  output  1  instruction returned this cycle is accepted into IF/ID.
REQ-017 flush  output  1  squash IF/ID and ID/EX contents this cycle.
REQ-018 imem_err  output  1  sticky fetch timeout error.

Function
REQ-019 The block SHALL implement states BOOT, FETCH, WAIT, ERR.
REQ-020 BOOT: imem_req=0; a 4-bit counter counts BOOT_HOLD cycles after reset deasserts, then the state SHALL move to FETCH.
REQ-021 FETCH and WAIT: imem_req=1 unless a redirect is active this cycle.
REQ-022 Redirect conditions: take = branch & zero_alu; jmp = jump & !take (branch priority over jump, being the older instruction).
REQ-023 Jump target SHALL be {pc_plus4[31:28], jump_index, 2'b00}.
REQ-024 On take or jmp in FETCH or WAIT: flush=1 and if_valid=0 combinationally that cycle; pc loads the target at the next edge; the wait counter clears; the next state is FETCH; stall is ignored.
REQ-025 Redirects in BOOT or ERR SHALL be ignored (flush=0, pc unchanged).
REQ-026 No redirect, imem_ready=1, stall=0: if_valid=1, pc loads pc_plus4, state FETCH, wait counter clears.
REQ-027 No redirect, imem_ready=1, stall=1: if_valid=0, pc holds, state FETCH, wait counter clears; the same address is refetched.
REQ-028 No redirect, imem_ready=0: if_valid=0, pc holds, state WAIT, wait counter increments (8-bit, saturating).
REQ-029 When the wait counter reaches MEM_TIMEOUT with imem_ready still 0, the state SHALL move to ERR at the next edge.
REQ-030 ERR: imem_req=0, if_valid=0, flush=0, imem_err=1, pc frozen; exit only by reset.
REQ-031 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000; no overflow flag.
REQ-032 pc[1:0] SHALL be taken from the loaded value unchanged (no forced alignment of branch_target).
REQ-033 flush and if_valid SHALL never be 1 in the same cycle.

Reset
REQ-034 reset=1 SHALL immediately force pc=RESET_PC, state BOOT, boot and wait counters 0, imem_req=0, if_valid=0, flush=0, imem_err=0.
REQ-035 Reset asserted mid-WAIT or in ERR SHALL abandon the outstanding request and clear imem_err without waiting for a clock edge.
REQ-036 pc_plus4 SHALL equal RESET_PC+4 throughout reset.

Verification
REQ-037 Boot/sequential: release reset, imem_ready=1 constant -> imem_req rises after 2 cycles; pc steps 0x0,0x4,0x8 with if_valid=1 each cycle.
REQ-038 Branch vs jump: at pc=0x40 assert branch=1, zero_alu=1, branch_target=0x100, jump=1 -> flush=1 for one cycle, next pc=0x100; with zero_alu=0 and jump_index=0x10 -> next pc=0x040.
REQ-039 Stall and wait: stall=1 for 3 cycles at pc=0x20 -> pc stays 0x20, if_valid=0; imem_ready=0 for 4 cycles -> WAIT, then ready -> if_valid=1, pc=0x24.
REQ-040 Timeout: imem_ready=0 held with MEM_TIMEOUT=15 -> imem_err=1 and imem_req=0 after 16 cycles; redirects ignored; reset clears imem_err asynchronously.
REQ-041 Wrap/redirect in WAIT: pc=0xFFFF_FFFC, ready -> pc=0x0; redirect during WAIT -> flush=1, pc=target, wait counter 0.
